// File: rtl/avr_pkg.sv
// AVR prefetch shared definitions: 32-bit opcode masks and address width.
// is_32bit_opcode() flags words that need their operand word alongside.
package avr_pkg;

  localparam int AVR_ADDR_W = 16;

  localparam logic [15:0] JMP_MASK   = 16'hFE0E;
  localparam logic [15:0] JMP_MATCH  = 16'h940C;
  localparam logic [15:0] CALL_MASK  = 16'hFE0E;
  localparam logic [15:0] CALL_MATCH = 16'h940E;
  localparam logic [15:0] LDS_MASK   = 16'hFE0F;
  localparam logic [15:0] LDS_MATCH  = 16'h9000;
  localparam logic [15:0] STS_MASK   = 16'hFE0F;
  localparam logic [15:0] STS_MATCH  = 16'h9200;

  function automatic logic is_32bit_opcode(
    input logic [15:0] op
  );
    return ((op & JMP_MASK) == JMP_MATCH)
        || ((op & CALL_MASK) == CALL_MATCH)
        || ((op & LDS_MASK) == LDS_MATCH)
        || ((op & STS_MASK) == STS_MATCH);
  endfunction

endpackage

// File: rtl/avr_prefetch_fifo.sv
// Circular word queue for the prefetcher; entries are {addr, word}.
// Pops one or two entries per cycle; flush empties it outright.
module avr_prefetch_fifo
  import avr_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4
) (
  input  logic                     CLK,
  input  logic                     RST,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop1,
  input  logic                     pop2,
  input  logic                     flush,
  output logic [WIDTH-1:0]         head,
  output logic [WIDTH-1:0]         next,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    rd;
  logic [PW-1:0]    wr;
  logic [PW-1:0]    rd_nxt;
  logic [CW-1:0]    cnt_nxt;

  assign head = mem[rd];
  assign next = mem[rd + PW'(1)];

  // Next read pointer and occupancy from this cycle's push/pop mix
  always_comb begin
    rd_nxt  = rd;
    cnt_nxt = count;
    if (push) cnt_nxt = cnt_nxt + CW'(1);
    if (pop2) begin
      rd_nxt  = rd + PW'(2);
      cnt_nxt = cnt_nxt - CW'(2);
    end else if (pop1) begin
      rd_nxt  = rd + PW'(1);
      cnt_nxt = cnt_nxt - CW'(1);
    end
  end

  // Pointer/count state; flush wins over push and pop
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      rd    <= '0;
      wr    <= '0;
      count <= '0;
    end else if (flush) begin
      rd    <= '0;
      wr    <= '0;
      count <= '0;
    end else begin
      rd    <= rd_nxt;
      count <= cnt_nxt;
      if (push) wr <= wr + PW'(1);
    end
  end

  // Storage array
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (push && !flush) begin
      mem[wr] <= push_data;
    end
  end

endmodule

// File: rtl/avr_prefetch.sv
// AVR instruction prefetch queue between program ROM and fetch/decode.
// Pairing of 32-bit opcodes is enabled by defining AVR_PREFETCH_PAIR32_EN.
module avr_prefetch
  import avr_pkg::*;
#(
  parameter int ADDR_W = AVR_ADDR_W,
  parameter int DEPTH  = 4
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              stall,
  input  logic              consume,
  input  logic              redirect,
  input  logic [ADDR_W-1:0] redirect_pc,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_en,
  input  logic [15:0]       mem_data,
  output logic              instr_valid,
  output logic [15:0]       instr,
  output logic [15:0]       instr_ext,
  output logic              instr_is32,
  output logic [ADDR_W-1:0] instr_pc
);

  localparam int CW = $clog2(DEPTH) + 1;
  localparam int EW = 16 + ADDR_W;

  logic [ADDR_W-1:0] fetch_pc;
  logic [ADDR_W-1:0] req_pc;
  logic              inflight;
  logic              push;
  logic              pop;
  logic              pop1;
  logic              pop2;
  logic              head32;
  logic [CW-1:0]     count;
  logic [EW-1:0]     head;
  logic [EW-1:0]     nxt;
  logic              nxt_unused;

  assign nxt_unused = ^nxt[EW-1:16];

  // Issue whenever queued plus arriving words leave room
  assign mem_en   = RST && !redirect
                 && ((int'(count) + int'(inflight)) < DEPTH);
  assign mem_addr = fetch_pc;

  // A response landing in a redirect cycle is from the old stream
  assign push = inflight && !redirect;

  // Fetch address and the one-deep in-flight tag
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      fetch_pc <= '0;
      req_pc   <= '0;
      inflight <= 1'b0;
    end else if (redirect) begin
      fetch_pc <= redirect_pc;
      inflight <= 1'b0;
    end else begin
      inflight <= mem_en;
      if (mem_en) begin
        req_pc   <= fetch_pc;
        fetch_pc <= fetch_pc + ADDR_W'(1);
      end
    end
  end

  avr_prefetch_fifo #(
    .WIDTH (EW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .CLK       (CLK),
    .RST       (RST),
    .push      (push),
    .push_data ({req_pc, mem_data}),
    .pop1      (pop1),
    .pop2      (pop2),
    .flush     (redirect),
    .head      (head),
    .next      (nxt),
    .count     (count)
  );

`ifdef AVR_PREFETCH_PAIR32_EN
  assign head32 = is_32bit_opcode(head[15:0]);
`else
  assign head32 = 1'b0;
`endif

  // Present the head; a 32-bit opcode waits for its operand word
  always_comb begin
    instr_valid = 1'b0;
    instr       = '0;
    instr_ext   = '0;
    instr_is32  = 1'b0;
    instr_pc    = '0;
    if (count != '0 && (!head32 || count >= CW'(2))) begin
      instr_valid = 1'b1;
      instr       = head[15:0];
      instr_pc    = head[EW-1:16];
      if (head32) begin
        instr_is32 = 1'b1;
        instr_ext  = nxt[15:0];
      end
    end
  end

  assign pop  = instr_valid && consume && !stall && !redirect;
  assign pop2 = pop && instr_is32;
  assign pop1 = pop && !instr_is32;

endmodule

// File: tb/tb_avr_prefetch.sv
// Directed bench for avr_prefetch with a 1-cycle synchronous ROM model.
// Expectations branch on AVR_PREFETCH_PAIR32_EN for the pairing cases.
module tb_avr_prefetch;

  logic        CLK = 1'b0;
  logic        RST;
  logic        stall;
  logic        consume;
  logic        redirect;
  logic [15:0] redirect_pc;
  logic [15:0] mem_addr;
  logic        mem_en;
  logic [15:0] mem_data;
  logic        instr_valid;
  logic [15:0] instr;
  logic [15:0] instr_ext;
  logic        instr_is32;
  logic [15:0] instr_pc;

  logic [15:0] rom [65536];
  int n_cmp = 0;
  int n_bad = 0;

  avr_prefetch dut (
    .CLK         (CLK),
    .RST         (RST),
    .stall       (stall),
    .consume     (consume),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .mem_addr    (mem_addr),
    .mem_en      (mem_en),
    .mem_data    (mem_data),
    .instr_valid (instr_valid),
    .instr       (instr),
    .instr_ext   (instr_ext),
    .instr_is32  (instr_is32),
    .instr_pc    (instr_pc)
  );

  always #5 CLK = ~CLK;

  // Synchronous ROM, one cycle read latency
  always @(posedge CLK) begin
    if (mem_en) mem_data <= rom[mem_addr];
  end

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_cmp++;
    assert (got === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  task automatic pres(input string tag,
                      input logic [15:0] i,
                      input logic [15:0] p);
    chk({tag, "_valid"}, 32'(instr_valid), 32'd1);
    chk({tag, "_instr"}, 32'(instr), 32'(i));
    chk({tag, "_pc"}, 32'(instr_pc), 32'(p));
  endtask

  task automatic single(input string tag);
    chk({tag, "_is32"}, 32'(instr_is32), 32'd0);
    chk({tag, "_ext"}, 32'(instr_ext), 32'd0);
  endtask

  task automatic zeros(input string tag);
    chk({tag, "_en"}, 32'(mem_en), 32'd0);
    chk({tag, "_addr"}, 32'(mem_addr), 32'd0);
    chk({tag, "_valid"}, 32'(instr_valid), 32'd0);
    chk({tag, "_instr"}, 32'(instr), 32'd0);
    chk({tag, "_ext"}, 32'(instr_ext), 32'd0);
    chk({tag, "_is32"}, 32'(instr_is32), 32'd0);
    chk({tag, "_pc"}, 32'(instr_pc), 32'd0);
  endtask

  task automatic step();
    @(posedge CLK);
    #2;
  endtask

  initial begin
    for (int i = 0; i < 65536; i++) rom[i] = 16'(16'h1000 + i);
    rom[0]     = 16'h0000;
    rom[1]     = 16'hE001;
    rom[2]     = 16'h0000;
    rom[3]     = 16'h0000;
    rom[4]     = 16'h940C;
    rom[5]     = 16'h0123;
    rom[16'hFFFF] = 16'h940C;
    mem_data    = 16'h0000;
    RST         = 1'b0;
    stall       = 1'b0;
    consume     = 1'b1;
    redirect    = 1'b0;
    redirect_pc = 16'h0000;

    repeat (2) @(posedge CLK);
    #2;
    zeros("rst");

    RST = 1'b1;
    #1;
    chk("c0_en", 32'(mem_en), 32'd1);
    chk("c0_addr", 32'(mem_addr), 32'd0);
    chk("c0_valid", 32'(instr_valid), 32'd0);
    step();
    chk("c1_addr", 32'(mem_addr), 32'd1);
    chk("c1_valid", 32'(instr_valid), 32'd0);
    step();
    pres("c2", 16'h0000, 16'd0);
    chk("c2_addr", 32'(mem_addr), 32'd2);
    step();
    pres("c3", 16'hE001, 16'd1);
    step();
    pres("c4", 16'h0000, 16'd2);
    step();
    pres("c5", 16'h0000, 16'd3);
    step();
`ifdef AVR_PREFETCH_PAIR32_EN
    chk("jmp_wait", 32'(instr_valid), 32'd0);
    step();
    pres("jmp", 16'h940C, 16'd4);
    chk("jmp_ext", 32'(instr_ext), 32'h0123);
    chk("jmp_is32", 32'(instr_is32), 32'd1);
`else
    pres("jmp_w0", 16'h940C, 16'd4);
    single("jmp_w0");
    step();
    pres("jmp_w1", 16'h0123, 16'd5);
    single("jmp_w1");
`endif
    step();
    pres("after_jmp", 16'h1006, 16'd6);

    step();
    consume = 1'b0;
    #1;
    pres("hold0", 16'h1007, 16'd7);
    for (int i = 1; i < 10; i++) begin
      step();
      pres("hold", 16'h1007, 16'd7);
    end
    chk("full_en", 32'(mem_en), 32'd0);
    chk("full_addr", 32'(mem_addr), 32'd11);

    for (int i = 0; i < 6; i++) begin
      step();
      consume = 1'b1;
      #1;
      pres("resume", 16'(16'h1007 + i), 16'(7 + i));
    end

    step();
    redirect    = 1'b1;
    redirect_pc = 16'h0040;
    #1;
    chk("redir_en", 32'(mem_en), 32'd0);
    pres("redir_head", 16'h100D, 16'd13);
    step();
    redirect = 1'b0;
    #1;
    chk("redir1_en", 32'(mem_en), 32'd1);
    chk("redir1_addr", 32'(mem_addr), 32'h40);
    chk("redir1_valid", 32'(instr_valid), 32'd0);
    step();
    chk("redir2_addr", 32'(mem_addr), 32'h41);
    chk("redir2_valid", 32'(instr_valid), 32'd0);
    step();
    pres("redir3", 16'h1040, 16'h0040);

    step();
    stall = 1'b1;
    #1;
    pres("stall0", 16'h1041, 16'h0041);
    step();
    pres("stall1", 16'h1041, 16'h0041);
    step();
    pres("stall2", 16'h1041, 16'h0041);
    step();
    stall = 1'b0;
    #1;
    pres("unstall", 16'h1041, 16'h0041);
    step();
    pres("unstall1", 16'h1042, 16'h0042);

    step();
    redirect    = 1'b1;
    redirect_pc = 16'hFFFE;
    #1;
    chk("wrap_en", 32'(mem_en), 32'd0);
    step();
    redirect = 1'b0;
    #1;
    chk("wrap1_addr", 32'(mem_addr), 32'hFFFE);
    chk("wrap1_valid", 32'(instr_valid), 32'd0);
    step();
    chk("wrap2_addr", 32'(mem_addr), 32'hFFFF);
    step();
    pres("wrap3", 16'h0FFE, 16'hFFFE);
    chk("wrap3_addr", 32'(mem_addr), 32'h0000);
    step();
`ifdef AVR_PREFETCH_PAIR32_EN
    chk("wrap4_wait", 32'(instr_valid), 32'd0);
    step();
    pres("wrap5", 16'h940C, 16'hFFFF);
    chk("wrap5_is32", 32'(instr_is32), 32'd1);
    chk("wrap5_ext", 32'(instr_ext), 32'h0000);
`else
    pres("wrap4", 16'h940C, 16'hFFFF);
    single("wrap4");
    step();
    pres("wrap5", 16'h0000, 16'h0000);
`endif
    step();
    pres("wrap6", 16'hE001, 16'h0001);

    step();
    RST = 1'b0;
    #1;
    zeros("midrst");
    step();
    RST = 1'b1;
    #1;
    chk("rel0_en", 32'(mem_en), 32'd1);
    chk("rel0_addr", 32'(mem_addr), 32'd0);
    chk("rel0_valid", 32'(instr_valid), 32'd0);
    step();
    chk("rel1_addr", 32'(mem_addr), 32'd1);
    step();
    pres("rel2", 16'h0000, 16'd0);
    step();
    pres("rel3", 16'hE001, 16'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
